// File: rtl/dmem_responder_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dmem_responder_if                                             |
// | Purpose  : Request/response channel bundle between CPU and data memory.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface dmem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_error;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_error
    );
endinterface
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dmem_responder                                                |
// | Purpose  : Word RAM behind a valid/ready port with programmable latency.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module dmem_responder #(
    parameter int WORDS       = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_responder_if.slave bus
);
    localparam int         IDX_W     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        write_q, write_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic        error_q, error_d;

    logic [31:0] mem [WORDS];

    logic             accept;
    logic             mem_op;
    logic             mem_we;
    logic             addr_err;
    logic [IDX_W-1:0] idx;

    assign accept   = (state_q == S_IDLE) && bus.req_valid;
    // WAIT always lasts WAIT_STATES+1 cycles, so the RAM is accessed on its final edge
    assign mem_op   = (state_q == S_WAIT) && (cnt_q == 4'd0);
    assign addr_err = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(WORDS));
    assign mem_we   = mem_op && write_q && !addr_err;
    assign idx      = addr_q[IDX_W+1:2];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            write_q <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            rdata_q <= 32'd0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_WAIT;
                    cnt_d   = WAIT_LOAD;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_comb begin
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        error_d = error_q;
        if (accept) begin
            write_d = bus.req_write;
            addr_d  = bus.req_addr;
            wdata_d = bus.req_wdata;
            be_d    = bus.req_be;
        end
        if (mem_op) begin
            error_d = addr_err;
            rdata_d = (!addr_err && !write_q) ? mem[idx] : 32'd0;
        end else if ((state_q == S_RESP) && bus.rsp_ready) begin
            rdata_d = 32'd0;
            error_d = 1'b0;
        end
    end

    // RAM is deliberately left out of reset so contents survive a reset pulse
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i]) begin
                    mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        bus.req_ready = (state_q == S_IDLE);
        bus.rsp_valid = (state_q == S_RESP);
        bus.rsp_rdata = rdata_q;
        bus.rsp_error = error_q;
    end
endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dmem_responder                                             |
// | Purpose  : Scoreboard bench for dmem_responder at 2 and 0 wait states.   |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_dmem_responder;
    localparam int LAT_A = 3;
    localparam int LAT_B = 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   tests;
    int   fails;
    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t e_a, e_b;
    bit   seen_a, seen_b;
    logic [31:0] hold_a, hold_b;
    logic        hold_ea, hold_eb;

    dmem_responder_if if_a();
    dmem_responder_if if_b();

    dmem_responder #(.WORDS(1024), .WAIT_STATES(2)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (if_a)
    );

    dmem_responder #(.WORDS(1024), .WAIT_STATES(0)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic timeout(input string nm);
        tests++;
        fails++;
        $display("FAIL %s: timeout waiting for DUT", nm);
    endtask

    always @(negedge clk) begin
        if (reset || !if_a.rsp_valid) begin
            seen_a = 1'b0;
        end else if (!seen_a) begin
            seen_a  = 1'b1;
            hold_a  = if_a.rsp_rdata;
            hold_ea = if_a.rsp_error;
            if (exp_a.size() == 0) begin
                timeout("unexpected_rsp_a");
            end else begin
                e_a = exp_a.pop_front();
                chk("rdata_a", if_a.rsp_rdata, e_a.rdata);
                chk("error_a", {31'd0, if_a.rsp_error}, {31'd0, e_a.err});
                chk("latency_a", 32'(cyc - e_a.acc), 32'(LAT_A));
            end
        end else begin
            chk("stable_rdata_a", if_a.rsp_rdata, hold_a);
            chk("stable_error_a", {31'd0, if_a.rsp_error}, {31'd0, hold_ea});
            chk("req_ready_in_resp_a", {31'd0, if_a.req_ready}, 32'd0);
        end
    end

    always @(negedge clk) begin
        if (reset || !if_b.rsp_valid) begin
            seen_b = 1'b0;
        end else if (!seen_b) begin
            seen_b  = 1'b1;
            hold_b  = if_b.rsp_rdata;
            hold_eb = if_b.rsp_error;
            if (exp_b.size() == 0) begin
                timeout("unexpected_rsp_b");
            end else begin
                e_b = exp_b.pop_front();
                chk("rdata_b", if_b.rsp_rdata, e_b.rdata);
                chk("error_b", {31'd0, if_b.rsp_error}, {31'd0, e_b.err});
                chk("latency_b", 32'(cyc - e_b.acc), 32'(LAT_B));
            end
        end else begin
            chk("stable_rdata_b", if_b.rsp_rdata, hold_b);
            chk("stable_error_b", {31'd0, if_b.rsp_error}, {31'd0, hold_eb});
        end
    end

    task automatic req_a(input logic w, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] er, input logic ee,
                         input bit push);
        int n;
        n = 0;
        @(negedge clk);
        if_a.req_valid = 1'b1;
        if_a.req_write = w;
        if_a.req_addr  = addr;
        if_a.req_wdata = wd;
        if_a.req_be    = be;
        while (!if_a.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!if_a.req_ready) begin
            timeout("accept_a");
        end else begin
            @(posedge clk);
            #1;
            if (push) exp_a.push_back('{er, ee, cyc});
        end
        if_a.req_valid = 1'b0;
        if_a.req_addr  = 32'h0000_0013;
        if_a.req_wdata = 32'h5A5A_5A5A;
        if_a.req_write = ~w;
    endtask

    task automatic req_b(input logic w, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input logic [31:0] er, input logic ee);
        int n;
        n = 0;
        @(negedge clk);
        if_b.req_valid = 1'b1;
        if_b.req_write = w;
        if_b.req_addr  = addr;
        if_b.req_wdata = wd;
        if_b.req_be    = be;
        while (!if_b.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!if_b.req_ready) begin
            timeout("accept_b");
        end else begin
            @(posedge clk);
            #1;
            exp_b.push_back('{er, ee, cyc});
        end
        if_b.req_valid = 1'b0;
        if_b.req_addr  = 32'h0000_0013;
    endtask

    task automatic done_a();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_a.size() != 0 || if_a.rsp_valid) && n < 100);
        if (n >= 100) timeout("done_a");
    endtask

    task automatic done_b();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_b.size() != 0 || if_b.rsp_valid) && n < 100);
        if (n >= 100) timeout("done_b");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tests = 0;
        fails = 0;
        reset = 1'b1;
        if_a.req_valid = 1'b0; if_a.req_write = 1'b0; if_a.req_addr = 32'd0;
        if_a.req_wdata = 32'd0; if_a.req_be = 4'd0; if_a.rsp_ready = 1'b1;
        if_b.req_valid = 1'b0; if_b.req_write = 1'b0; if_b.req_addr = 32'd0;
        if_b.req_wdata = 32'd0; if_b.req_be = 4'd0; if_b.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        chk("reset_req_ready", {31'd0, if_a.req_ready}, 32'd1);
        chk("reset_rsp_valid", {31'd0, if_a.rsp_valid}, 32'd0);
        chk("reset_rsp_rdata", if_a.rsp_rdata, 32'd0);
        chk("reset_rsp_error", {31'd0, if_a.rsp_error}, 32'd0);
        chk("reset_req_ready_b", {31'd0, if_b.req_ready}, 32'd1);

        // Store then load with two wait states
        req_a(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0, 1'b1); done_a();
        req_a(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b1); done_a();

        // Byte enables
        req_a(1'b1, 32'h20, 32'h1122_3344, 4'hF, 32'd0, 1'b0, 1'b1); done_a();
        req_a(1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, 32'd0, 1'b0, 1'b1); done_a();
        req_a(1'b0, 32'h20, 32'h0, 4'hF, 32'h11BB_33DD, 1'b0, 1'b1); done_a();
        req_a(1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 32'd0, 1'b0, 1'b1); done_a();
        req_a(1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB_33DD, 1'b0, 1'b1); done_a();

        // Errors and range boundaries
        req_a(1'b1, 32'h0, 32'h0BAD_F00D, 4'hF, 32'd0, 1'b0, 1'b1); done_a();
        req_a(1'b0, 32'h13, 32'h0, 4'hF, 32'd0, 1'b1, 1'b1); done_a();
        req_a(1'b1, 32'h1000, 32'h9999_9999, 4'hF, 32'd0, 1'b1, 1'b1); done_a();
        req_a(1'b0, 32'h0, 32'h0, 4'hF, 32'h0BAD_F00D, 1'b0, 1'b1); done_a();
        req_a(1'b1, 32'hFFC, 32'h7777_1234, 4'hF, 32'd0, 1'b0, 1'b1); done_a();
        req_a(1'b0, 32'hFFC, 32'h0, 4'hF, 32'h7777_1234, 1'b0, 1'b1); done_a();
        req_a(1'b0, 32'h8000_0000, 32'h0, 4'hF, 32'd0, 1'b1, 1'b1); done_a();

        // Response backpressure with input churn while held
        if_a.rsp_ready = 1'b0;
        req_a(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b1);
        n = 0;
        while (!if_a.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!if_a.rsp_valid) timeout("bp_valid_a");
        repeat (5) begin
            @(posedge clk);
            #1;
            if_a.req_addr  = $urandom;
            if_a.req_valid = 1'b1;
            @(negedge clk);
            chk("bp_rsp_valid", {31'd0, if_a.rsp_valid}, 32'd1);
            chk("bp_rsp_rdata", if_a.rsp_rdata, 32'hDEAD_BEEF);
        end
        @(posedge clk);
        #1;
        if_a.req_valid = 1'b0;
        if_a.rsp_ready = 1'b1;
        done_a();

        // Reset while a store waits: write must be lost
        req_a(1'b1, 32'h40, 32'hCAFE_F00D, 4'hF, 32'd0, 1'b0, 1'b1); done_a();
        req_a(1'b1, 32'h40, 32'h1234_5678, 4'hF, 32'd0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("midrst_req_ready", {31'd0, if_a.req_ready}, 32'd1);
        chk("midrst_rsp_valid", {31'd0, if_a.rsp_valid}, 32'd0);
        chk("midrst_rsp_rdata", if_a.rsp_rdata, 32'd0);
        chk("midrst_rsp_error", {31'd0, if_a.rsp_error}, 32'd0);
        repeat (4) @(negedge clk);
        reset = 1'b0;
        chk("post_rst_rsp_valid", {31'd0, if_a.rsp_valid}, 32'd0);
        req_a(1'b0, 32'h40, 32'h0, 4'hF, 32'hCAFE_F00D, 1'b0, 1'b1); done_a();

        // Zero wait states
        req_b(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0); done_b();
        req_b(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b0); done_b();
        req_b(1'b1, 32'h10, 32'h0102_0304, 4'b1010, 32'd0, 1'b0); done_b();
        req_b(1'b0, 32'h10, 32'h0, 4'h0, 32'h01AD_03EF, 1'b0); done_b();
        req_b(1'b0, 32'h12, 32'h0, 4'h0, 32'd0, 1'b1); done_b();

        chk("queue_empty_a", 32'(exp_a.size()), 32'd0);
        chk("queue_empty_b", 32'(exp_b.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
